// File: rtl/fmul_72bit_issue.sv
// fmul_72bit_issue: credit-based issue/collect front end for a 72-bit float multiplier
//   iCLOCK, iRESET_SYNC        clock, synchronous active-high reset
//   iREQ/oBUSY/iDATA_A/B       client operand channel
//   oMUL_REQ/iMUL_BUSY/oMUL_A/B operand channel to the multiplier
//   iMUL_VALID/oMUL_BUSY/iMUL_DATA result channel from the multiplier
//   oVALID/iBUSY/oDATA         result channel to the client (FIFO head)
//   oREQ_COUNT/oRES_COUNT      issued / delivered transaction counters
module fmul_72bit_issue #(
    parameter int P_DEPTH   = 4,
    parameter int P_DEPTH_N = 2,
    parameter int P_CNT_W   = 16
) (
    input  logic               iCLOCK,
    input  logic               iRESET_SYNC,
    input  logic               iREQ,
    output logic               oBUSY,
    input  logic [71:0]        iDATA_A,
    input  logic [71:0]        iDATA_B,
    output logic               oMUL_REQ,
    input  logic               iMUL_BUSY,
    output logic [71:0]        oMUL_A,
    output logic [71:0]        oMUL_B,
    input  logic               iMUL_VALID,
    output logic               oMUL_BUSY,
    input  logic [71:0]        iMUL_DATA,
    output logic               oVALID,
    input  logic               iBUSY,
    output logic [71:0]        oDATA,
    output logic [P_CNT_W-1:0] oREQ_COUNT,
    output logic [P_CNT_W-1:0] oRES_COUNT
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t               state_q, state_d;
    logic [71:0]          a_q, a_d, b_q, b_d;
    logic                 hold_q, hold_d;
    logic [P_DEPTH_N:0]   in_flight_q, in_flight_d, count_q, count_d;
    logic [P_DEPTH_N-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [P_CNT_W-1:0]   req_cnt_q, req_cnt_d, res_cnt_q, res_cnt_d;
    logic [71:0]          mem_q [P_DEPTH];
    logic                 credit_ok, cli_xfer, mul_xfer, push, pop, full, empty;

    // Every outstanding multiply owns a FIFO slot, so results never back-pressure.
    assign credit_ok  = ((P_DEPTH_N+2)'(in_flight_q) + (P_DEPTH_N+2)'(count_q)) < (P_DEPTH_N+2)'(P_DEPTH);
    assign full       = count_q == (P_DEPTH_N+1)'(P_DEPTH);
    assign empty      = count_q == '0;
    assign oBUSY      = iRESET_SYNC | (state_q == ISSUE);
    assign oMUL_BUSY  = iRESET_SYNC | full;
    // hold_q keeps a raised request up until it transfers, even if credit drops.
    assign oMUL_REQ   = (state_q == ISSUE) & (credit_ok | hold_q);
    assign oMUL_A     = a_q;
    assign oMUL_B     = b_q;
    assign oVALID     = ~empty;
    assign oDATA      = empty ? '0 : mem_q[rd_q];
    assign oREQ_COUNT = req_cnt_q;
    assign oRES_COUNT = res_cnt_q;
    assign cli_xfer   = iREQ & ~oBUSY;
    assign mul_xfer   = oMUL_REQ & ~iMUL_BUSY;
    assign push       = iMUL_VALID & ~oMUL_BUSY;
    assign pop        = oVALID & ~iBUSY;

    always_comb begin
        state_d     = cli_xfer ? ISSUE : (mul_xfer ? IDLE : state_q);
        a_d         = cli_xfer ? iDATA_A : a_q;
        b_d         = cli_xfer ? iDATA_B : b_q;
        hold_d      = oMUL_REQ & ~mul_xfer;
        // A stray result with nothing in flight is still stored; in_flight floors at 0.
        in_flight_d = in_flight_q + (P_DEPTH_N+1)'(mul_xfer) - (P_DEPTH_N+1)'(push && in_flight_q != '0);
        count_d     = count_q + (P_DEPTH_N+1)'(push) - (P_DEPTH_N+1)'(pop);
        wr_d        = wr_q + P_DEPTH_N'(push);
        rd_d        = rd_q + P_DEPTH_N'(pop);
        req_cnt_d   = req_cnt_q + P_CNT_W'(mul_xfer);
        res_cnt_d   = res_cnt_q + P_CNT_W'(pop);
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            hold_q      <= 1'b0;
            in_flight_q <= '0;
            count_q     <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            req_cnt_q   <= '0;
            res_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            hold_q      <= hold_d;
            in_flight_q <= in_flight_d;
            count_q     <= count_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            req_cnt_q   <= req_cnt_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (push)
            mem_q[wr_q] <= iMUL_DATA;
    end
endmodule

// File: tb/tb_fmul_72bit_issue.sv
// tb_fmul_72bit_issue: scoreboard bench for fmul_72bit_issue with a latency-3 multiplier model
module tb_fmul_72bit_issue;
    localparam logic [71:0] ONE  = 72'h3ff000000000000000;
    localparam logic [71:0] TWO  = 72'h400000000000000000;
    localparam logic [71:0] HALF = 72'h3fe000000000000000;
    localparam logic [71:0] TQ   = 72'h3fe800000000000000;

    logic        iCLOCK = 0, iRESET_SYNC = 1, iREQ = 0, iMUL_BUSY = 0, iBUSY = 1;
    logic [71:0] iDATA_A = '0, iDATA_B = '0, iMUL_DATA;
    logic        iMUL_VALID, oBUSY, oMUL_REQ, oMUL_BUSY, oVALID;
    logic [71:0] oMUL_A, oMUL_B, oDATA;
    logic [15:0] oREQ_COUNT, oRES_COUNT;

    logic        manual = 0, man_valid = 0, mdl_valid = 0;
    logic [71:0] man_data = '0, mdl_data = '0, mon_e;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [71:0] exp_q[$];

    typedef struct {logic [71:0] data; int due;} mres_t;
    mres_t mq[$];

    assign iMUL_VALID = manual ? man_valid : mdl_valid;
    assign iMUL_DATA  = manual ? man_data : mdl_data;

    fmul_72bit_issue dut (
        .iCLOCK(iCLOCK), .iRESET_SYNC(iRESET_SYNC), .iREQ(iREQ), .oBUSY(oBUSY),
        .iDATA_A(iDATA_A), .iDATA_B(iDATA_B), .oMUL_REQ(oMUL_REQ), .iMUL_BUSY(iMUL_BUSY),
        .oMUL_A(oMUL_A), .oMUL_B(oMUL_B), .iMUL_VALID(iMUL_VALID), .oMUL_BUSY(oMUL_BUSY),
        .iMUL_DATA(iMUL_DATA), .oVALID(oVALID), .iBUSY(iBUSY), .oDATA(oDATA),
        .oREQ_COUNT(oREQ_COUNT), .oRES_COUNT(oRES_COUNT)
    );

    initial forever #5 iCLOCK = ~iCLOCK;
    initial forever begin @(posedge iCLOCK); cyc++; end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [71:0] mul_model(input logic [71:0] a, input logic [71:0] b);
        if (a == ONE && b == ONE)  return ONE;
        if (a == ONE && b == TWO)  return TWO;
        if (a == ONE && b == HALF) return HALF;
        if (a == ONE && b == TQ)   return TQ;
        if (a == HALF && b == TWO) return ONE;
        return 72'h0;
    endfunction

    // Multiplier model: in-order, result presented ~3 cycles after acceptance.
    initial forever begin
        mres_t r;
        @(negedge iCLOCK);
        if (!manual) begin
            if (mdl_valid && !oMUL_BUSY) mq.delete(0);
            if (oMUL_REQ && !iMUL_BUSY) begin
                r.data = mul_model(oMUL_A, oMUL_B);
                r.due  = cyc + 3;
                mq.push_back(r);
            end
        end
        @(posedge iCLOCK);
        #1;
        mdl_valid = 0;
        mdl_data  = '0;
        if (!manual && mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                mdl_valid = 1;
                mdl_data  = mq[0].data;
            end
        end
    end

    // Monitor: a client pop happens at the next posedge whenever oVALID && !iBUSY.
    initial forever begin
        @(negedge iCLOCK);
        if (!iRESET_SYNC && oVALID && !iBUSY) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got %h required none", oDATA);
            end else begin
                mon_e = exp_q.pop_front();
                if (oDATA !== mon_e) begin
                    n_fail++;
                    $display("FAIL result_data: got %h required %h", oDATA, mon_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [71:0] a, input logic [71:0] b, input logic [71:0] exp);
        iREQ = 1; iDATA_A = a; iDATA_B = b;
        for (int i = 0; i < 200; i++) begin
            if (!oBUSY) begin
                tick();
                iREQ = 0;
                exp_q.push_back(exp);
                return;
            end
            tick();
        end
        iREQ = 0;
        chk("send_timeout", 72'd1, 72'd0);
    endtask

    task automatic wait_mul();
        for (int i = 0; i < 200; i++) begin
            if (oMUL_REQ && !iMUL_BUSY) begin
                tick();
                return;
            end
            tick();
        end
        chk("mul_timeout", 72'd1, 72'd0);
    endtask

    task automatic wait_res(input string name, input int n);
        for (int i = 0; i < 300 && oRES_COUNT != 16'(n); i++) tick();
        chk(name, 72'(oRES_COUNT), 72'(n));
    endtask

    task automatic man_push(input logic [71:0] d);
        man_valid = 1; man_data = d;
        tick();
        man_valid = 0;
    endtask

    initial begin
        logic [71:0] a0, b0;
        logic [15:0] rq0, rs0;
        bit          bad;
        #1;
        chk("rst_busy", 72'(oBUSY), 72'd1);
        chk("rst_mul_busy", 72'(oMUL_BUSY), 72'd1);
        repeat (3) tick();
        iRESET_SYNC = 0;
        #1;
        chk("rst_valid", 72'(oVALID), 72'd0);
        chk("rst_mul_req", 72'(oMUL_REQ), 72'd0);
        chk("rst_data", oDATA, 72'd0);
        chk("rst_mul_a", oMUL_A, 72'd0);
        chk("rst_req_cnt", 72'(oREQ_COUNT), 72'd0);
        chk("rst_res_cnt", 72'(oRES_COUNT), 72'd0);
        chk("rst_idle_busy", 72'(oBUSY), 72'd0);

        // Single 1.0 x 1.0
        iBUSY = 0;
        send(ONE, ONE, ONE);
        chk("req_latency", 72'(oMUL_REQ), 72'd1);
        wait_res("single_res_cnt", 1);
        chk("single_req_cnt", 72'(oREQ_COUNT), 72'd1);

        // Back-to-back stream
        send(ONE, ONE, ONE);
        send(ONE, TWO, TWO);
        send(ONE, HALF, HALF);
        send(ONE, TQ, TQ);
        send(HALF, TWO, ONE);
        wait_res("stream_res_cnt", 6);
        chk("stream_req_cnt", 72'(oREQ_COUNT), 72'd6);

        // Credit stall with client stalled
        iBUSY = 1;
        send(ONE, ONE, ONE);
        send(ONE, TWO, TWO);
        send(ONE, HALF, HALF);
        send(ONE, TQ, TQ);
        send(HALF, TWO, ONE);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (oMUL_REQ) bad = 1;
            tick();
        end
        chk("credit_no_req", 72'(bad), 72'd0);
        chk("credit_busy", 72'(oBUSY), 72'd1);
        chk("credit_full", 72'(oMUL_BUSY), 72'd1);
        chk("credit_head", oDATA, ONE);
        chk("credit_req_cnt", 72'(oREQ_COUNT), 72'd10);
        iBUSY = 0;
        tick();
        chk("credit_release_req", 72'(oMUL_REQ), 72'd1);
        wait_res("credit_res_cnt", 11);
        chk("credit_req_cnt2", 72'(oREQ_COUNT), 72'd11);

        // Multiplier stall
        iMUL_BUSY = 1;
        send(ONE, TQ, TQ);
        a0 = oMUL_A; b0 = oMUL_B; rq0 = oREQ_COUNT;
        chk("mstall_req", 72'(oMUL_REQ), 72'd1);
        chk("mstall_a", a0, ONE);
        chk("mstall_b", b0, TQ);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!oMUL_REQ || oMUL_A != a0 || oMUL_B != b0 || oREQ_COUNT != rq0) bad = 1;
        end
        chk("mstall_stable", 72'(bad), 72'd0);
        iMUL_BUSY = 0;
        tick();
        chk("mstall_req_cnt", 72'(oREQ_COUNT), 72'd12);
        chk("mstall_req_drop", 72'(oMUL_REQ), 72'd0);
        wait_res("mstall_res_cnt", 12);

        // Simultaneous issue, push and pop with in_flight=2, fifo_count=1
        manual = 1;
        iBUSY = 1;
        send(ONE, ONE, ONE);  wait_mul();
        send(ONE, TWO, TWO);  wait_mul();
        send(ONE, HALF, HALF); wait_mul();
        man_push(ONE);
        send(ONE, TQ, TQ);
        chk("sim_req_ready", 72'(oMUL_REQ), 72'd1);
        rq0 = oREQ_COUNT; rs0 = oRES_COUNT;
        man_valid = 1; man_data = TWO; iBUSY = 0;
        tick();
        man_valid = 0; iBUSY = 1;
        chk("sim_req_cnt", 72'(oREQ_COUNT), 72'(rq0 + 16'd1));
        chk("sim_res_cnt", 72'(oRES_COUNT), 72'(rs0 + 16'd1));
        chk("sim_valid", 72'(oVALID), 72'd1);
        chk("sim_head", oDATA, TWO);
        iBUSY = 0;
        man_push(HALF);
        man_push(TQ);
        wait_res("sim_drain_cnt", 16);

        // Reset mid-operation with 2 in flight and 1 in FIFO
        iBUSY = 1;
        send(ONE, ONE, ONE);  wait_mul();
        send(ONE, TWO, TWO);  wait_mul();
        send(ONE, HALF, HALF); wait_mul();
        man_push(ONE);
        iRESET_SYNC = 1;
        #1;
        chk("mrst_busy", 72'(oBUSY), 72'd1);
        chk("mrst_mul_busy", 72'(oMUL_BUSY), 72'd1);
        tick();
        iRESET_SYNC = 0;
        #1;
        chk("mrst_valid", 72'(oVALID), 72'd0);
        chk("mrst_mul_req", 72'(oMUL_REQ), 72'd0);
        chk("mrst_req_cnt", 72'(oREQ_COUNT), 72'd0);
        chk("mrst_res_cnt", 72'(oRES_COUNT), 72'd0);
        exp_q.delete();
        exp_q.push_back(TWO);
        exp_q.push_back(HALF);
        iBUSY = 0;
        man_push(TWO);
        man_push(HALF);
        wait_res("mrst_drain_cnt", 2);
        manual = 0;
        send(HALF, TWO, ONE);
        wait_res("mrst_post_res_cnt", 3);
        chk("mrst_post_req_cnt", 72'(oREQ_COUNT), 72'd1);

        repeat (3) tick();
        chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
